// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch unit and the PC/next-address logic:
// FSM encoding, opcode/funct constants and next-PC source encodings.
package instr_fetch_unit_pkg;

  // Fetch FSM encoding, kept as plain constants for legacy tools
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  // Opcodes that steer the next PC
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;

  // R-type functs that steer the next PC
  localparam logic [5:0] JR_FUNCT      = 6'h08;
  localparam logic [5:0] SYSCALL_FUNCT = 6'h0C;

  // Next-PC source select, shared with the address generator
  localparam logic [1:0] PCSRC_SEQ     = 2'b00;
  localparam logic [1:0] PCSRC_JUMP    = 2'b01;
  localparam logic [1:0] PCSRC_JR      = 2'b10;
  localparam logic [1:0] PCSRC_SYSCALL = 2'b11;

  typedef logic [2:0] fetch_state_t;

  // Next-PC control fields decoded from the held instruction
  typedef struct packed {
    logic [1:0]  pcsrc;
    logic [25:0] jump;
    logic [16:0] imm;
  } next_pc_ctl_t;

  // Instruction fetches must be word aligned
  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/grant/response bus.
// master = fetch unit, slave = instruction memory.
interface instr_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/instr_fetch_unit_fetch_decode.sv
// Combinational next-PC field decode from the held instruction word.
// pcsrc is forced to sequential whenever no valid word is held.
module fetch_decode
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0]  instr,
  input  logic         valid,
  output next_pc_ctl_t ctl
);
  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  // Select the next-PC source; jump target and offset are raw fields
  always_comb begin
    ctl.pcsrc = PCSRC_SEQ;
    if (valid) begin
      if (opcode == OPC_J || opcode == OPC_JAL)
        ctl.pcsrc = PCSRC_JUMP;
      else if (opcode == OPC_RTYPE && funct == JR_FUNCT)
        ctl.pcsrc = PCSRC_JR;
      else if (opcode == OPC_RTYPE && funct == SYSCALL_FUNCT)
        ctl.pcsrc = PCSRC_SYSCALL;
    end
    ctl.jump = instr[25:0];
    ctl.imm  = {instr[15], instr[15:0]};
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: requests the word at pc, holds it until decode
// consumes it, decodes next-PC controls and stalls the PC meanwhile.
// Responses are in order; outstanding/drop counters let flushed
// requests drain while a fresh request is already in flight.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               pc,
  input  logic                      flush,
  instr_fetch_unit_if.master        imem,
  output logic                      instr_valid,
  output logic [31:0]               instr,
  input  logic                      instr_ready,
  output logic                      pc_stall,
  output logic [1:0]                pcsrc,
  output logic [25:0]               jump,
  output logic [16:0]               imm,
  output logic                      misaligned
);
  fetch_state_t state, state_nxt;
  logic [1:0]   outst, outst_nxt;   // requests granted, response not yet seen
  logic [1:0]   drop, drop_nxt;     // of those, responses to be discarded
  logic         accept;
  logic         rsp;
  logic         capture;
  logic         flushable;
  next_pc_ctl_t ctl;

  // A misaligned pc never reaches the bus
  assign imem.req  = (state == ST_REQ) && word_aligned(pc[1:0]);
  assign imem.addr = imem.req ? pc : 32'h0;

  assign accept    = imem.req && imem.gnt;
  assign rsp       = imem.rvalid && (outst != 2'd0);
  assign flushable = (state == ST_REQ) || (state == ST_WAIT) || (state == ST_HOLD);
  assign capture   = (state == ST_WAIT) && rsp && (drop == 2'd0) && !flush;

  assign pc_stall   = !((state == ST_HOLD) && instr_ready);
  assign misaligned = (state == ST_ERR);

  // Track in-flight requests; a flush turns every in-flight one into a drop
  always_comb begin
    outst_nxt = outst + {1'b0, accept} - {1'b0, rsp};
    drop_nxt  = drop;
    if (rsp && drop != 2'd0)
      drop_nxt = drop - 2'd1;
    if (flush && flushable)
      drop_nxt = outst_nxt;
  end

  // Fetch sequencing; flush outranks grant, response and consume
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = ST_REQ;
      ST_REQ: begin
        if (flush)
          state_nxt = accept ? ST_WAIT : ST_REQ;
        else if (!word_aligned(pc[1:0]))
          state_nxt = ST_ERR;
        else if (accept)
          state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (flush)
          state_nxt = ST_REQ;
        else if (rsp) begin
          if (drop == 2'd0)
            state_nxt = ST_HOLD;
          else if (outst == drop)
            // only dropped requests were in flight: fetch again
            state_nxt = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (flush || instr_ready)
          state_nxt = ST_REQ;
      end
      ST_ERR:  state_nxt = ST_ERR;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, counters and the held instruction register
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      outst       <= 2'd0;
      drop        <= 2'd0;
      instr_valid <= 1'b0;
      instr       <= 32'h0;
    end else begin
      state <= state_nxt;
      outst <= outst_nxt;
      drop  <= drop_nxt;
      if (capture) begin
        instr       <= imem.rdata;
        instr_valid <= 1'b1;
      end else if (state == ST_HOLD && (flush || instr_ready)) begin
        instr_valid <= 1'b0;
      end
    end
  end

  fetch_decode u_decode (
    .instr (instr),
    .valid (instr_valid),
    .ctl   (ctl)
  );

  assign pcsrc = ctl.pcsrc;
  assign jump  = ctl.jump;
  assign imm   = ctl.imm;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch-side counterpart of the PC/next-address logic. It takes the current `pc` and fetches the instruction word over a request/grant/response instruction-memory handshake. It holds the word until decode accepts it, and decodes the next-PC control fields (`pcsrc`, `jump`, `imm`) that feed back into address generation. It also drives `pc_stall` so the PC advances only when an instruction has been consumed.

## Interface
- `JR_FUNCT`, 6'h08: R-type funct selecting register-indirect jump.
- `SYSCALL_FUNCT`, 6'h0C: R-type funct selecting syscall vector.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `pc`  in  32  current PC from address generation.
- `flush`  in  1  PC redirected this cycle; drop any in-flight or held instruction.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address (= `pc` while `imem_req`).
- `imem_gnt`  in  1  memory accepted request this cycle.
- `imem_rvalid`  in  1  response data valid.
- `imem_rdata`  in  32  response instruction word.
- `instr_valid`  out  1  `instr` holds a valid instruction.
- `instr`  out  32  fetched instruction.
- `instr_ready`  in  1  decode consumes `instr` this cycle.
- `pc_stall`  out  1  1 = PC must hold; 0 = PC may load next value.
- `pcsrc`  out  2  00 seq/branch, 01 J/JAL, 10 JR, 11 syscall.
- `jump`  out  26  `instr[25:0]`.
- `imm`  out  17  `{instr[15], instr[15:0]}`, sign-extended byte offset.
- `misaligned`  out  1  sticky: fetch attempted with `pc[1:0]` != 0.

## Operation
- States: IDLE, REQ, WAIT, HOLD, ERR.
- IDLE to REQ: unconditionally, one cycle after reset release.
- REQ:
  - `imem_req` = 1 and `imem_addr` = `pc`.
  - If `pc[1:0]` != 0, go to ERR instead, with no request issued.
  - On `imem_gnt`, go to WAIT.
- WAIT: on `imem_rvalid`, register `imem_rdata` into `instr`, set `instr_valid`, and go to HOLD.
- HOLD: on `instr_ready`, clear `instr_valid` and go to REQ.
- ERR: `misaligned` = 1, no further requests. Only `rst` exits ERR.
- Decode is combinational from the `instr` register and valid only while `instr_valid` = 1; otherwise `pcsrc` = 00.
  - opcode 000010 or 000011 gives `pcsrc` = 01.
  - opcode 000000 with funct = `JR_FUNCT` gives 10.
  - opcode 000000 with funct = `SYSCALL_FUNCT` gives 11.
  - Anything else gives 00.
- `pc_stall` = 0 only in the HOLD cycle where `instr_ready` = 1; it is 1 in all other cycles and states.
- `flush` (priority over everything except `rst`):
  - HOLD: clear `instr_valid`, go to REQ.
  - WAIT without `imem_rvalid`: set internal `drop`, go to REQ; the next `imem_rvalid` is discarded and clears `drop`.
  - WAIT with `imem_rvalid` in the same cycle: discard the data, go to REQ.
  - REQ without `imem_gnt`: stay in REQ; the address follows the new `pc`.
  - REQ with `imem_gnt`: set `drop`, go to WAIT (the response is discarded, then the block re-requests).
  - ERR: ignored.
- While `drop` = 1, a new request may be granted. Responses are strictly in order and at most one request is outstanding beyond the dropped one.

## Timing
- Reset values: state IDLE, `imem_req` = 0, `instr_valid` = 0, `instr` = 0, `pcsrc` = 00, `pc_stall` = 1, `misaligned` = 0, `drop` = 0.
- Minimum fetch: REQ with `gnt` in cycle 0, `rvalid` in cycle 1, `instr_valid` = 1 in cycle 2.
- Throughput with single-cycle memory: one instruction per 3 cycles.
- A consume cycle (`instr_ready` in HOLD) and the PC update share one edge; the next REQ presents the updated `pc`.
- `imem_addr` is stable from `req` assertion to `gnt`, unless `flush` occurs.
- `instr_ready` with `instr_valid` = 0 is ignored.

## Structure
- Shared package holds the state encoding, the opcode constants (J = 6'h02, JAL = 6'h03, RTYPE = 6'h00) and the `pcsrc` encodings; the address generator uses the same `pcsrc` constants.
- One sub-module, `fetch_decode`: combinational `instr` to `pcsrc`/`jump`/`imm`.

## Test plan
- Reset, `pc` = 0, memory grants immediately and returns 32'h0800_0010 next cycle: `imem_req` in cycle 1, `instr_valid` in cycle 3, `pcsrc` = 01, `jump` = 26'h10.
- `instr` = 32'h1022_FFFC (beq), `instr_ready` held: `imm` = 17'h1FFFC, `pcsrc` = 00, `pc_stall` low for exactly one cycle.
- `instr` = 32'h03E0_0008 then 32'h0000_000C: `pcsrc` = 10, then 11.
- `gnt` delayed 3 cycles: `imem_req`/`imem_addr` stable for 4 cycles and `pc_stall` = 1 throughout.
- `flush` in WAIT before `rvalid`: the stale `rdata` is discarded (`instr_valid` stays 0), and the refetch at the new `pc` delivers the correct word.
- `pc` = 32'h0000_0006 at REQ: no request, `misaligned` = 1, held until `rst`; after `rst` all outputs return to reset values.
